// File: rtl/arp_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : arp_ctrl
//  Brief    : ARP control stage. Auto-answers incoming ARP requests, resolves
//             and ages the peer MAC for DES_IP with periodic retries, and
//             sequences the ARP transmitter through a start/done handshake.
//  Revision : 1.0 - initial release
// ============================================================================
module arp_ctrl #(
    parameter logic [31:0] DES_IP       = {8'd192, 8'd168, 8'd1, 8'd102},
    parameter logic [31:0] RETRY_CYCLES = 32'd125_000_000,
    parameter logic [31:0] AGE_CYCLES   = 32'd3_750_000_000,
    parameter logic [31:0] TX_TIMEOUT   = 32'd4096
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        arp_rx_done,
    input  logic        arp_rx_type,
    input  logic [47:0] src_mac,
    input  logic [31:0] src_ip,
    input  logic        tx_done,
    input  logic        user_req,
    output logic        arp_tx_en,
    output logic        arp_tx_type,
    output logic [47:0] des_mac,
    output logic [31:0] des_ip,
    output logic        peer_valid,
    output logic [47:0] peer_mac,
    output logic [31:0] peer_ip,
    output logic        tx_timeout_err
);

    localparam logic [1:0]  c_IDLE      = 2'd0;
    localparam logic [1:0]  c_START     = 2'd1;
    localparam logic [1:0]  c_WAIT_DONE = 2'd2;
    localparam logic [47:0] c_BCAST_MAC = 48'hff_ff_ff_ff_ff_ff;
    // Loaded in START so that expiry lands TX_TIMEOUT cycles after START.
    localparam logic [31:0] c_TO_LOAD   = (TX_TIMEOUT == 32'd0) ? 32'd0 : TX_TIMEOUT - 32'd1;

    logic [1:0]  r_state;
    logic [1:0]  w_state_nxt;
    logic        r_rep_pend;
    logic [47:0] r_rep_mac;
    logic [31:0] r_rep_ip;
    logic        r_req_pend;
    logic [31:0] r_retry_cnt;
    logic [31:0] r_age_cnt;
    logic [31:0] r_to_cnt;
    logic        w_take_rep;
    logic        w_take_req;
    logic        w_to_expire;
    logic        w_rx_req;
    logic        w_rx_match;
    logic        w_retry_fire;

    assign w_rx_req     = arp_rx_done & ~arp_rx_type;
    assign w_rx_match   = arp_rx_done & arp_rx_type & (src_ip == DES_IP);
    assign w_retry_fire = ~peer_valid & (r_retry_cnt == 32'd0);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= c_IDLE;
        else        r_state <= w_state_nxt;
    end

    // Next-state decode; replies win over requests, tx_done wins over timeout.
    always_comb begin
        w_state_nxt = r_state;
        w_take_rep  = 1'b0;
        w_take_req  = 1'b0;
        w_to_expire = 1'b0;
        arp_tx_en   = 1'b0;
        case (r_state)
            c_IDLE: begin
                if (r_rep_pend) begin
                    w_take_rep  = 1'b1;
                    w_state_nxt = c_START;
                end else if (r_req_pend) begin
                    w_take_req  = 1'b1;
                    w_state_nxt = c_START;
                end
            end
            c_START: begin
                arp_tx_en   = 1'b1;
                w_state_nxt = c_WAIT_DONE;
            end
            c_WAIT_DONE: begin
                if (tx_done) begin
                    w_state_nxt = c_IDLE;
                end else if (r_to_cnt <= 32'd1) begin
                    w_to_expire = 1'b1;
                    w_state_nxt = c_IDLE;
                end
            end
            default: w_state_nxt = c_IDLE;
        endcase
    end

    // Pending flags and reply slot; a new event set in the same cycle as a clear survives.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rep_pend <= 1'b0;
            r_rep_mac  <= 48'd0;
            r_rep_ip   <= 32'd0;
            r_req_pend <= 1'b0;
        end else begin
            if (w_take_rep) r_rep_pend <= 1'b0;
            if (w_rx_req) begin
                r_rep_pend <= 1'b1;
                r_rep_mac  <= src_mac;
                r_rep_ip   <= src_ip;
            end
            if (w_take_req) r_req_pend <= 1'b0;
            if (user_req || w_retry_fire) r_req_pend <= 1'b1;
        end
    end

    // Retry countdown while unresolved; parked at full value while the peer is known.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                        r_retry_cnt <= 32'd0;
        else if (peer_valid)               r_retry_cnt <= RETRY_CYCLES;
        else if (r_retry_cnt == 32'd0)     r_retry_cnt <= RETRY_CYCLES;
        else                               r_retry_cnt <= r_retry_cnt - 32'd1;
    end

    // Peer cache with aging; a matching reply on the expiry cycle keeps the entry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            peer_valid <= 1'b0;
            peer_mac   <= 48'd0;
            peer_ip    <= 32'd0;
            r_age_cnt  <= 32'd0;
        end else if (w_rx_match) begin
            peer_valid <= 1'b1;
            peer_mac   <= src_mac;
            peer_ip    <= DES_IP;
            r_age_cnt  <= AGE_CYCLES;
        end else if (peer_valid) begin
            if (r_age_cnt == 32'd0) begin
                peer_valid <= 1'b0;
                peer_mac   <= 48'd0;
                peer_ip    <= 32'd0;
            end else begin
                r_age_cnt <= r_age_cnt - 32'd1;
            end
        end
    end

    // Transmit descriptor, captured on the IDLE decision and held through WAIT_DONE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            arp_tx_type <= 1'b0;
            des_mac     <= c_BCAST_MAC;
            des_ip      <= 32'd0;
        end else if (w_take_rep) begin
            arp_tx_type <= 1'b1;
            des_mac     <= r_rep_mac;
            des_ip      <= r_rep_ip;
        end else if (w_take_req) begin
            arp_tx_type <= 1'b0;
            des_mac     <= c_BCAST_MAC;
            des_ip      <= DES_IP;
        end
    end

    // Transmit watchdog and its sticky error flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_to_cnt       <= 32'd0;
            tx_timeout_err <= 1'b0;
        end else begin
            if (r_state == c_START)
                r_to_cnt <= c_TO_LOAD;
            else if (r_state == c_WAIT_DONE && r_to_cnt != 32'd0)
                r_to_cnt <= r_to_cnt - 32'd1;
            if (w_to_expire) tx_timeout_err <= 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_arp_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_arp_ctrl
//  Brief    : Self-checking bench for arp_ctrl. Expected transmit descriptors
//             are queued as stimulus is applied and popped on each arp_tx_en.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_arp_ctrl;

    localparam logic [31:0] c_DES_IP = 32'hC0A8_0166;
    localparam int          c_RETRY  = 100;
    localparam int          c_AGE    = 200;
    localparam int          c_TXTO   = 16;
    localparam logic [47:0] c_BCAST  = 48'hff_ff_ff_ff_ff_ff;
    localparam logic [47:0] c_PEER   = 48'h00_11_22_AA_BB_CC;

    typedef struct packed {
        logic        typ;
        logic [47:0] mac;
        logic [31:0] ip;
    } tx_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        arp_rx_done = 1'b0;
    logic        arp_rx_type = 1'b0;
    logic [47:0] src_mac = 48'd0;
    logic [31:0] src_ip = 32'd0;
    logic        tx_done = 1'b0;
    logic        user_req = 1'b0;
    logic        arp_tx_en;
    logic        arp_tx_type;
    logic [47:0] des_mac;
    logic [31:0] des_ip;
    logic        peer_valid;
    logic [47:0] peer_mac;
    logic [31:0] peer_ip;
    logic        tx_timeout_err;

    int  cyc = 0;
    int  checks = 0;
    int  errors = 0;
    tx_t exp_q[$];

    arp_ctrl #(
        .DES_IP(c_DES_IP), .RETRY_CYCLES(c_RETRY), .AGE_CYCLES(c_AGE), .TX_TIMEOUT(c_TXTO)
    ) dut (
        .clk(clk), .rst_n(rst_n), .arp_rx_done(arp_rx_done), .arp_rx_type(arp_rx_type),
        .src_mac(src_mac), .src_ip(src_ip), .tx_done(tx_done), .user_req(user_req),
        .arp_tx_en(arp_tx_en), .arp_tx_type(arp_tx_type), .des_mac(des_mac), .des_ip(des_ip),
        .peer_valid(peer_valid), .peer_mac(peer_mac), .peer_ip(peer_ip),
        .tx_timeout_err(tx_timeout_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- stimulus helpers (no checking inside) ----------------
    task automatic pulse_rx(input logic typ, input logic [47:0] mac, input logic [31:0] ip,
                            output int at);
        @(posedge clk); #1;
        arp_rx_done = 1'b1; arp_rx_type = typ; src_mac = mac; src_ip = ip; at = cyc;
        @(posedge clk); #1;
        arp_rx_done = 1'b0;
    endtask

    task automatic pulse_user(output int at);
        @(posedge clk); #1; user_req = 1'b1; at = cyc;
        @(posedge clk); #1; user_req = 1'b0;
    endtask

    task automatic pulse_done(output int at);
        @(posedge clk); #1; tx_done = 1'b1; at = cyc;
        @(posedge clk); #1; tx_done = 1'b0;
    endtask

    task automatic wait_tx(input int budget, output bit seen, output tx_t obs, output int at);
        seen = 1'b0; obs = '0; at = -1;
        for (int i = 0; i < budget && !seen; i++) begin
            @(negedge clk);
            if (arp_tx_en === 1'b1) begin
                seen = 1'b1; obs = {arp_tx_type, des_mac, des_ip}; at = cyc;
            end
        end
    endtask

    task automatic count_tx(input int n, output int hits);
        hits = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (arp_tx_en !== 1'b0) hits++;
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({arp_tx_en, arp_tx_type, peer_valid, tx_timeout_err} !== 4'b0) begin
            errors++;
            $display("FAIL reset_flags: got en/type/valid/err=%b expected 0000",
                     {arp_tx_en, arp_tx_type, peer_valid, tx_timeout_err});
        end
        checks++;
        if (des_mac !== c_BCAST || des_ip !== 32'd0) begin
            errors++;
            $display("FAIL reset_des: got mac=%h ip=%h expected mac=%h ip=0", des_mac, des_ip, c_BCAST);
        end
        checks++;
        if (peer_mac !== 48'd0 || peer_ip !== 32'd0) begin
            errors++;
            $display("FAIL reset_peer: got mac=%h ip=%h expected 0/0", peer_mac, peer_ip);
        end
    endtask

    task automatic test_auto_request();
        int rel, at1, at2, d; bit seen; tx_t obs, ex;
        @(posedge clk); #1; rst_n = 1'b1; rel = cyc;
        exp_q.push_back('{1'b0, c_BCAST, c_DES_IP});
        wait_tx(10, seen, obs, at1);
        ex = exp_q.pop_front();
        checks++;
        if (!seen || obs !== ex || at1 != rel + 2) begin
            errors++;
            $display("FAIL auto_req_first: seen=%0b at=%0d got %h expected %h at %0d", seen, at1, obs, ex, rel + 2);
        end
        pulse_done(d);
        exp_q.push_back('{1'b0, c_BCAST, c_DES_IP});
        wait_tx(c_RETRY + 20, seen, obs, at2);
        ex = exp_q.pop_front();
        checks++;
        if (!seen || obs !== ex || at2 - at1 != c_RETRY + 1) begin
            errors++;
            $display("FAIL auto_req_retry: seen=%0b interval=%0d got %h expected %h interval %0d",
                     seen, at2 - at1, obs, ex, c_RETRY + 1);
        end
        pulse_done(d);
    endtask

    task automatic test_peer_resolve_and_age();
        int c, hits, inv, at, d; bit seen; tx_t obs, ex;
        pulse_rx(1'b1, c_PEER, c_DES_IP, c);
        @(negedge clk);
        checks++;
        if (peer_valid !== 1'b1 || peer_mac !== c_PEER || peer_ip !== c_DES_IP) begin
            errors++;
            $display("FAIL peer_resolve: got valid=%b mac=%h ip=%h expected 1 %h %h",
                     peer_valid, peer_mac, peer_ip, c_PEER, c_DES_IP);
        end
        count_tx(c_AGE, hits);
        checks++;
        if (hits != 0 || peer_valid !== 1'b1) begin
            errors++;
            $display("FAIL peer_hold: got tx_pulses=%0d valid=%b expected 0 pulses valid=1", hits, peer_valid);
        end
        @(negedge clk); inv = cyc;
        checks++;
        if (peer_valid !== 1'b0 || peer_mac !== 48'd0 || peer_ip !== 32'd0) begin
            errors++;
            $display("FAIL peer_expire: got valid=%b mac=%h ip=%h expected 0 0 0", peer_valid, peer_mac, peer_ip);
        end
        exp_q.push_back('{1'b0, c_BCAST, c_DES_IP});
        wait_tx(c_RETRY + 20, seen, obs, at);
        ex = exp_q.pop_front();
        checks++;
        if (!seen || obs !== ex || at != inv + c_RETRY + 2) begin
            errors++;
            $display("FAIL req_restart: seen=%0b at=%0d got %h expected %h at %0d", seen, at, obs, ex, inv + c_RETRY + 2);
        end
        pulse_done(d);
    endtask

    task automatic test_reply_request();
        int c, at; bit seen; tx_t obs, ex;
        pulse_rx(1'b1, c_PEER, c_DES_IP, c);
        // A reply from a non-peer IP must neither be cached nor answered.
        pulse_rx(1'b1, 48'h12_34_56_78_9A_BC, 32'hC0A8_0199, c);
        @(negedge clk);
        checks++;
        if (peer_mac !== c_PEER) begin
            errors++;
            $display("FAIL foreign_reply: got peer_mac=%h expected %h", peer_mac, c_PEER);
        end
        pulse_rx(1'b0, 48'h0A_0B_0C_0D_0E_0F, 32'hC0A8_0132, c);
        exp_q.push_back('{1'b1, 48'h0A_0B_0C_0D_0E_0F, 32'hC0A8_0132});
        wait_tx(10, seen, obs, at);
        ex = exp_q.pop_front();
        checks++;
        if (!seen || obs !== ex || at != c + 2) begin
            errors++;
            $display("FAIL reply_latency: seen=%0b at=%0d got %h expected %h at %0d", seen, at, obs, ex, c + 2);
        end
        pulse_done(c);
    endtask

    task automatic test_back_to_back();
        int c, u, d, at, hits; bit seen; tx_t obs, ex;
        pulse_rx(1'b1, c_PEER, c_DES_IP, c);
        pulse_user(u);
        exp_q.push_back('{1'b0, c_BCAST, c_DES_IP});
        wait_tx(10, seen, obs, at);
        ex = exp_q.pop_front();
        checks++;
        if (!seen || obs !== ex || at != u + 2) begin
            errors++;
            $display("FAIL user_req: seen=%0b at=%0d got %h expected %h at %0d", seen, at, obs, ex, u + 2);
        end
        pulse_rx(1'b0, 48'h0A_0B_0C_0D_0E_01, 32'hC0A8_0132, c);
        pulse_rx(1'b0, 48'h0A_0B_0C_0D_0E_02, 32'hC0A8_0133, c);
        pulse_user(u);
        exp_q.push_back('{1'b1, 48'h0A_0B_0C_0D_0E_02, 32'hC0A8_0133});
        exp_q.push_back('{1'b0, c_BCAST, c_DES_IP});
        for (int k = 0; k < 2; k++) begin
            pulse_done(d);
            wait_tx(10, seen, obs, at);
            ex = exp_q.pop_front();
            checks++;
            if (!seen || obs !== ex || at != d + 2) begin
                errors++;
                $display("FAIL queued_tx%0d: seen=%0b at=%0d got %h expected %h at %0d", k, seen, at, obs, ex, d + 2);
            end
        end
        pulse_done(d);
        count_tx(30, hits);
        checks++;
        if (hits != 0) begin
            errors++;
            $display("FAIL single_reply: got %0d extra tx pulses expected 0", hits);
        end
    endtask

    task automatic test_timeout();
        int c, u, s, at; bit seen; tx_t obs, ex;
        pulse_rx(1'b1, c_PEER, c_DES_IP, c);
        pulse_user(u);
        exp_q.push_back('{1'b0, c_BCAST, c_DES_IP});
        wait_tx(10, seen, obs, s);
        ex = exp_q.pop_front();
        checks++;
        if (!seen || obs !== ex) begin
            errors++;
            $display("FAIL to_start: seen=%0b got %h expected %h", seen, obs, ex);
        end
        if (!seen) s = cyc;
        pulse_rx(1'b0, 48'h0A_0B_0C_0D_0E_4D, 32'hC0A8_014D, c);
        exp_q.push_back('{1'b1, 48'h0A_0B_0C_0D_0E_4D, 32'hC0A8_014D});
        for (int i = 0; i < 40 && cyc < s + c_TXTO - 1; i++) @(negedge clk);
        checks++;
        if (tx_timeout_err !== 1'b0) begin
            errors++;
            $display("FAIL to_early: got err=%b at cycle %0d expected 0", tx_timeout_err, cyc - s);
        end
        @(negedge clk);
        checks++;
        if (tx_timeout_err !== 1'b1) begin
            errors++;
            $display("FAIL to_set: got err=%b at cycle %0d expected 1", tx_timeout_err, cyc - s);
        end
        wait_tx(10, seen, obs, at);
        ex = exp_q.pop_front();
        checks++;
        if (!seen || obs !== ex || at != s + c_TXTO + 1) begin
            errors++;
            $display("FAIL to_next: seen=%0b at=%0d got %h expected %h at %0d", seen, at, obs, ex, s + c_TXTO + 1);
        end
        pulse_done(c);
    endtask

    task automatic test_reset_mid_wait();
        int c, u, rel, at, hits; bit seen; tx_t obs, ex;
        pulse_rx(1'b1, c_PEER, c_DES_IP, c);
        pulse_user(u);
        wait_tx(10, seen, obs, at);
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL rst_pre_tx: got no tx pulse expected one");
        end
        pulse_rx(1'b0, 48'h0A_0B_0C_0D_0E_55, 32'hC0A8_0155, c);
        @(posedge clk); #3; rst_n = 1'b0; #1;
        checks++;
        if ({arp_tx_en, arp_tx_type, peer_valid, tx_timeout_err} !== 4'b0 ||
            des_mac !== c_BCAST || des_ip !== 32'd0 || peer_mac !== 48'd0 || peer_ip !== 32'd0) begin
            errors++;
            $display("FAIL rst_async: got en/type/valid/err=%b des=%h/%h peer=%h/%h expected 0000 %h/0 0/0",
                     {arp_tx_en, arp_tx_type, peer_valid, tx_timeout_err}, des_mac, des_ip, peer_mac, peer_ip, c_BCAST);
        end
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1; rst_n = 1'b1; rel = cyc;
        exp_q.push_back('{1'b0, c_BCAST, c_DES_IP});
        wait_tx(10, seen, obs, at);
        ex = exp_q.pop_front();
        checks++;
        if (!seen || obs !== ex || at != rel + 2) begin
            errors++;
            $display("FAIL rst_first_tx: seen=%0b at=%0d got %h expected %h at %0d", seen, at, obs, ex, rel + 2);
        end
        pulse_done(c);
        count_tx(30, hits);
        checks++;
        if (hits != 0) begin
            errors++;
            $display("FAIL rst_stale_reply: got %0d tx pulses expected 0", hits);
        end
    endtask

    initial begin
        test_reset();
        test_auto_request();
        test_peer_resolve_and_age();
        test_reply_request();
        test_back_to_back();
        test_timeout();
        test_reset_mid_wait();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected completion");
        $fatal(1);
    end

endmodule
`default_nettype wire

// File: doc/arp_ctrl.md
Name: arp_ctrl

Overview:
- Control stage between the ARP receive/transmit pair and the user logic.
- Consumes the receive side's arp_rx_done/arp_rx_type/src_mac/src_ip and drives the transmit side's arp_tx_en/arp_tx_type/des_mac/des_ip, using tx_done as the completion handshake.
- Answers incoming ARP requests automatically and resolves the peer MAC for DES_IP, with retry and aging.
- Presents a cached peer MAC/IP with a valid flag to the UDP path.

Parameters:
- DES_IP, {8'd192,8'd168,8'd1,8'd102}: peer IP to resolve; replies from other IPs are not cached.
- RETRY_CYCLES, 125_000_000: cycles between automatic requests while the peer is unresolved (1 s at 125 MHz).
- AGE_CYCLES, 32'd3_750_000_000: cycles after the last matching reply before the cache entry is invalidated (30 s).
- TX_TIMEOUT, 4096: cycles to wait for tx_done before abandoning a transmit.

Ports:
- clk  in  1  single clock for rx and tx paths.
- rst_n  in  1  asynchronous active-low reset.
- arp_rx_done  in  1  one-cycle pulse: a frame was received and parsed.
- arp_rx_type  in  1  0 = request, 1 = reply; valid with arp_rx_done.
- src_mac  in  48  sender MAC; valid with arp_rx_done.
- src_ip  in  32  sender IP; valid with arp_rx_done.
- tx_done  in  1  one-cycle pulse: the transmit side finished its frame.
- user_req  in  1  one-cycle pulse: force an ARP request now.
- arp_tx_en  out  1  one-cycle transmit start pulse.
- arp_tx_type  out  1  0 = request, 1 = reply.
- des_mac  out  48  destination MAC for the transmit.
- des_ip  out  32  destination IP for the transmit.
- peer_valid  out  1  cache holds a live MAC for DES_IP.
- peer_mac  out  48  cached MAC.
- peer_ip  out  32  always equal to DES_IP once valid; 0 otherwise.
- tx_timeout_err  out  1  sticky; set when tx_done does not arrive within TX_TIMEOUT; cleared only by reset.

Behaviour:
- Reset (asynchronous, rst_n low):
  - all outputs 0, except des_mac = 48'hff_ff_ff_ff_ff_ff;
  - FSM to IDLE;
  - pending flags cleared;
  - retry counter loaded to 0, so the first request goes out on the first IDLE cycle after reset.
- Receive handling, every cycle, independent of FSM state:
  - On arp_rx_done with type 0: latch src_mac/src_ip into the reply slot and set rep_pend. A second request before service overwrites the slot; the latest sender wins and only one reply is sent.
  - On arp_rx_done with type 1 and src_ip == DES_IP: the next cycle sets peer_mac = src_mac, peer_valid = 1, peer_ip = DES_IP, and reloads the age counter to AGE_CYCLES.
  - A type-1 frame with src_ip != DES_IP is ignored.
- Request generation:
  - While peer_valid = 0, the retry counter counts down in every state; at 0 it sets req_pend and reloads RETRY_CYCLES.
  - user_req sets req_pend regardless of peer_valid.
  - While peer_valid = 1, the retry counter is held at RETRY_CYCLES.
- Aging:
  - While peer_valid = 1, the age counter decrements each cycle.
  - At 0, peer_valid goes to 0 and peer_mac/peer_ip go to 0.
  - A matching reply in the same cycle as expiry wins: the entry stays valid and the counter reloads.
- FSM:
  - IDLE: if rep_pend, go to START with type 1, des_mac/des_ip from the reply slot, and clear rep_pend. Otherwise if req_pend, go to START with type 0, des_mac = ff..ff, des_ip = DES_IP, and clear req_pend. Replies always take priority over requests.
  - START: arp_tx_en = 1 for exactly this cycle; des_*/type stay stable from this cycle until WAIT_DONE exits; go to WAIT_DONE and load the timeout counter.
  - WAIT_DONE: on tx_done go to IDLE. On timeout expiry set tx_timeout_err and go to IDLE. tx_done in any other state is ignored.
- Timing and event ordering:
  - Latency from arp_rx_done (request) to arp_tx_en is 2 cycles when IDLE: latch, IDLE decision, START.
  - A pending flag set in the same cycle the FSM clears another flag is preserved.
  - An rx event arriving during WAIT_DONE is queued and served after tx_done.
  - Back-to-back transmits take a minimum of 1 IDLE cycle between WAIT_DONE and the next START.
- Counter width: counters are 32-bit unsigned and must not wrap below 0.

Test Plan:
- Reset, then idle with no rx traffic (RETRY_CYCLES = 100): arp_tx_en pulses at cycle ~2 with type 0, des_mac = ff..ff, des_ip = C0A80166; after tx_done, the next request follows 100 cycles after the previous retry reload.
- Reply rx_done with src_ip = C0A80166 and src_mac = 001122AABBCC: peer_valid = 1 and peer_mac = 001122AABBCC the next cycle; no further auto-requests; expiry after AGE_CYCLES (set to 200) clears peer_valid and restarts the requests.
- Request rx_done from 192.168.1.50 / MAC 0A0B0C0D0E0F while IDLE: arp_tx_en 2 cycles later with type 1, des_ip = C0A80132, des_mac = 0A0B0C0D0E0F.
- Two requests (IPs .50, then .51) during WAIT_DONE, followed by user_req: after tx_done, exactly one reply to .51 is sent, then one request, in that order.
- tx_done withheld (TX_TIMEOUT = 16): tx_timeout_err = 1 sixteen cycles after START; FSM returns to IDLE and serves the next pending item.
- rst_n asserted mid-WAIT_DONE with a reply pending: all outputs reset immediately; after release, no stale reply is sent and only the auto-request appears.
